// File: rtl/step_motion_ctrl.sv
// step_motion_ctrl: half-step stepper motor move controller.
// Accepts one move command at a time (direction, half-step count, period in
// clk0 cycles), steps through the 8-entry half-step coil table at the
// requested rate, keeps an absolute signed position and reports completion
// with a one-cycle done pulse. aborted qualifies done when the move was cut
// short by abort.
//
// Ports:
//   clk0, reset (async, active-low)
//   cmd_valid/cmd_ready, cmd_dir, cmd_steps, cmd_period : move command
//   abort     : synchronous stop request, honoured only while running
//   hold_en   : keep coils energized while idle
//   phase     : coil drive pattern
//   busy, done, aborted : move status
//   position  : signed absolute half-step position
//   remaining : half-steps still to be taken
module step_motion_ctrl #(
  parameter int unsigned COUNT_W  = 16,
  parameter int unsigned PERIOD_W = 16
) (
  input  logic                clk0,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_dir,
  input  logic [COUNT_W-1:0]  cmd_steps,
  input  logic [PERIOD_W-1:0] cmd_period,
  input  logic                abort,
  input  logic                hold_en,
  output logic [3:0]          phase,
  output logic                busy,
  output logic                done,
  output logic                aborted,
  output logic signed [31:0]  position,
  output logic [COUNT_W-1:0]  remaining
);

  localparam int unsigned POS_W = 32;
  localparam int unsigned IDX_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Half-step coil pattern for a table index
  function automatic logic [3:0] half_step(input logic [IDX_W-1:0] i);
    logic [3:0] p;
    case (i)
      3'd0:    p = 4'b1001;
      3'd1:    p = 4'b0001;
      3'd2:    p = 4'b0011;
      3'd3:    p = 4'b0010;
      3'd4:    p = 4'b0110;
      3'd5:    p = 4'b0100;
      3'd6:    p = 4'b1100;
      default: p = 4'b1000;
    endcase
    return p;
  endfunction

  state_t                    state_q, state_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic signed [POS_W-1:0]   pos_q, pos_d;
  logic [COUNT_W-1:0]        rem_q, rem_d;
  logic [PERIOD_W-1:0]       timer_q, timer_d;
  logic [PERIOD_W-1:0]       per_q, per_d;
  logic                      dir_q, dir_d;
  logic                      aborted_q, aborted_d;
  logic [PERIOD_W-1:0]       p_eff_c;

  // Periods below 2 are clamped so each half-step lasts at least two cycles
  assign p_eff_c = (cmd_period < PERIOD_W'(2)) ? PERIOD_W'(2) : cmd_period;

  // State and datapath registers
  always_ff @(posedge clk0 or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      pos_q     <= '0;
      rem_q     <= '0;
      timer_q   <= '0;
      per_q     <= PERIOD_W'(2);
      dir_q     <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      pos_q     <= pos_d;
      rem_q     <= rem_d;
      timer_q   <= timer_d;
      per_q     <= per_d;
      dir_q     <= dir_d;
      aborted_q <= aborted_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pos_d     = pos_q;
    rem_d     = rem_q;
    timer_d   = timer_q;
    per_d     = per_q;
    dir_d     = dir_q;
    aborted_d = 1'b0;
    case (state_q)
      IDLE: begin
        // abort is deliberately ignored here so a coincident command still starts
        if (cmd_valid) begin
          dir_d = cmd_dir;
          per_d = p_eff_c;
          rem_d = cmd_steps;
          if (cmd_steps == '0) begin
            state_d = DONE;
          end else begin
            timer_d = p_eff_c - PERIOD_W'(1);
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (abort) begin
          // abort wins over a step due on the same edge
          state_d   = DONE;
          aborted_d = 1'b1;
        end else if (timer_q == '0) begin
          idx_d   = dir_q ? (idx_q + IDX_W'(1)) : (idx_q - IDX_W'(1));
          pos_d   = dir_q ? (pos_q + 32'sd1) : (pos_q - 32'sd1);
          rem_d   = rem_q - COUNT_W'(1);
          timer_d = per_q - PERIOD_W'(1);
          if (rem_q == COUNT_W'(1)) begin
            state_d = DONE;
          end
        end else begin
          timer_d = timer_q - PERIOD_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Status decode straight from the state register
  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign aborted   = aborted_q;
  assign position  = pos_q;
  assign remaining = rem_q;

  // Coils released only when idle without hold; reset leaves index 0 so
  // hold_en alone selects 1001 or 0000 during reset
  assign phase = ((state_q == IDLE) && !hold_en) ? 4'b0000 : half_step(idx_q);

endmodule

// File: tb/tb_step_motion_ctrl.sv
module tb_step_motion_ctrl;

  localparam int unsigned COUNT_W  = 16;
  localparam int unsigned PERIOD_W = 16;

  logic                clk0;
  logic                reset;
  logic                cmd_valid;
  logic                cmd_ready;
  logic                cmd_dir;
  logic [COUNT_W-1:0]  cmd_steps;
  logic [PERIOD_W-1:0] cmd_period;
  logic                abort;
  logic                hold_en;
  logic [3:0]          phase;
  logic                busy;
  logic                done;
  logic                aborted;
  logic signed [31:0]  position;
  logic [COUNT_W-1:0]  remaining;

  step_motion_ctrl #(.COUNT_W(COUNT_W), .PERIOD_W(PERIOD_W)) dut (
    .clk0       (clk0),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_dir    (cmd_dir),
    .cmd_steps  (cmd_steps),
    .cmd_period (cmd_period),
    .abort      (abort),
    .hold_en    (hold_en),
    .phase      (phase),
    .busy       (busy),
    .done       (done),
    .aborted    (aborted),
    .position   (position),
    .remaining  (remaining)
  );

  initial clk0 = 1'b0;
  always #5 clk0 = ~clk0;

  typedef struct {
    int         cyc;
    logic [3:0] ph;
  } step_exp_t;

  typedef struct {
    int                 cyc;
    logic               ab;
    logic [31:0]        pos;
    logic [COUNT_W-1:0] rem;
    logic [3:0]         ph;
  } done_exp_t;

  step_exp_t step_q[$];
  done_exp_t done_q[$];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  logic [3:0] prev_ph = 4'b0000;

  always @(posedge clk0) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every coil change during a move and every done pulse is popped
  // from the scoreboard and compared
  always @(negedge clk0) begin
    if (reset) begin
      if (busy && (phase !== prev_ph)) begin
        if (step_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_step: got phase %b at cycle %0d, expected none", phase, cyc);
        end else begin
          step_exp_t s;
          s = step_q.pop_front();
          chk("step_cycle", 32'(cyc), 32'(s.cyc));
          chk("step_phase", 32'(phase), 32'(s.ph));
        end
      end
      if (done) begin
        if (done_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_done: got done at cycle %0d, expected none", cyc);
        end else begin
          done_exp_t d;
          d = done_q.pop_front();
          chk("done_cycle", 32'(cyc), 32'(d.cyc));
          chk("done_aborted", 32'(aborted), 32'(d.ab));
          chk("done_position", position, d.pos);
          chk("done_remaining", 32'(remaining), 32'(d.rem));
          chk("done_phase", 32'(phase), 32'(d.ph));
        end
      end
    end
    prev_ph = phase;
  end

  // Present one command; k returns the accepting edge number
  task automatic issue(input logic dir, input int steps, input int per,
                       input logic with_abort, output int k);
    int n;
    n = 0;
    @(negedge clk0);
    while (!cmd_ready && n < 200) begin
      @(negedge clk0);
      n++;
    end
    if (!cmd_ready) begin
      tests++; fails++;
      $display("FAIL cmd_ready_timeout: got cmd_ready=0, expected 1");
    end
    cmd_valid  = 1'b1;
    cmd_dir    = dir;
    cmd_steps  = COUNT_W'(steps);
    cmd_period = PERIOD_W'(per);
    abort      = with_abort;
    @(posedge clk0);
    #1;
    k          = cyc;
    cmd_valid  = 1'b0;
    abort      = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk0);
    while (busy && n < 300) begin
      @(negedge clk0);
      n++;
    end
    if (busy) begin
      tests++; fails++;
      $display("FAIL idle_timeout: got busy=1, expected 0");
    end
  endtask

  task automatic push_step(input int c, input logic [3:0] p);
    step_exp_t s;
    s.cyc = c; s.ph = p;
    step_q.push_back(s);
  endtask

  task automatic push_done(input int c, input logic ab, input logic [31:0] pos,
                           input int rem, input logic [3:0] p);
    done_exp_t d;
    d.cyc = c; d.ab = ab; d.pos = pos; d.rem = COUNT_W'(rem); d.ph = p;
    done_q.push_back(d);
  endtask

  task automatic pulse_reset();
    @(negedge clk0);
    reset = 1'b0;
    @(negedge clk0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_position", position, 32'd0);
    chk("rst_phase_hold", 32'(phase), 32'b1001);
    reset = 1'b1;
  endtask

  initial begin
    int k;
    reset      = 1'b0;
    cmd_valid  = 1'b0;
    cmd_dir    = 1'b0;
    cmd_steps  = '0;
    cmd_period = '0;
    abort      = 1'b0;
    hold_en    = 1'b0;

    // Reset state, coils released then held
    repeat (2) @(negedge clk0);
    chk("reset_phase_nohold", 32'(phase), 32'b0000);
    chk("reset_ready", 32'(cmd_ready), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_aborted", 32'(aborted), 32'd0);
    chk("reset_position", position, 32'd0);
    chk("reset_remaining", 32'(remaining), 32'd0);
    hold_en = 1'b1;
    #1;
    chk("reset_phase_hold", 32'(phase), 32'b1001);
    @(negedge clk0);
    reset = 1'b1;

    // Reverse 2 steps, period 0 clamped to 2, wraps index 0 -> 7 -> 6
    issue(1'b0, 2, 0, 1'b0, k);
    push_step(k + 2, 4'b1000);
    push_step(k + 4, 4'b1100);
    push_done(k + 4, 1'b0, 32'hFFFF_FFFE, 0, 4'b1100);
    wait_idle();

    // Zero-step move: done right after accept, nothing moves
    issue(1'b1, 0, 5, 1'b0, k);
    push_done(k, 1'b0, 32'hFFFF_FFFE, 0, 4'b1100);
    wait_idle();
    chk("idle_hold_phase", 32'(phase), 32'b1100);

    // Forward 3 steps, period 4, from index 0
    pulse_reset();
    issue(1'b1, 3, 4, 1'b0, k);
    push_step(k + 4, 4'b0001);
    push_step(k + 8, 4'b0011);
    push_step(k + 12, 4'b0010);
    push_done(k + 12, 1'b0, 32'd3, 0, 4'b0010);
    wait_idle();

    // Abort on the cycle whose edge would take step 2
    pulse_reset();
    issue(1'b1, 5, 3, 1'b0, k);
    push_step(k + 3, 4'b0001);
    push_done(k + 6, 1'b1, 32'd1, 4, 4'b0001);
    repeat (5) @(posedge clk0);
    @(negedge clk0);
    abort = 1'b1;
    @(posedge clk0);
    #1;
    abort = 1'b0;
    wait_idle();
    chk("aborted_cleared", 32'(aborted), 32'd0);

    // Command presented together with abort in IDLE is still accepted
    issue(1'b1, 1, 2, 1'b1, k);
    push_step(k + 2, 4'b0011);
    push_done(k + 2, 1'b0, 32'd2, 0, 4'b0011);
    wait_idle();
    hold_en = 1'b0;
    @(negedge clk0);
    chk("idle_release_phase", 32'(phase), 32'b0000);
    hold_en = 1'b1;
    @(negedge clk0);

    // Reset mid-move discards the move without a done pulse
    issue(1'b1, 4, 3, 1'b0, k);
    push_step(k + 3, 4'b0010);
    repeat (4) @(posedge clk0);
    @(negedge clk0);
    reset = 1'b0;
    @(negedge clk0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_position", position, 32'd0);
    chk("midrst_remaining", 32'(remaining), 32'd0);
    chk("midrst_phase", 32'(phase), 32'b1001);
    reset = 1'b1;

    // Next move starts from table entry 1001
    issue(1'b0, 1, 2, 1'b0, k);
    push_step(k + 2, 4'b1000);
    push_done(k + 2, 1'b0, 32'hFFFF_FFFF, 0, 4'b1000);
    wait_idle();

    // Forward wrap 7 -> 0
    issue(1'b1, 1, 2, 1'b0, k);
    push_step(k + 2, 4'b1001);
    push_done(k + 2, 1'b0, 32'd0, 0, 4'b1001);
    wait_idle();

    repeat (3) @(negedge clk0);
    chk("steps_drained", 32'(step_q.size()), 32'd0);
    chk("dones_drained", 32'(done_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
